ballot_tally: RTL

- Sequential, parametrised plurality voter for the voting-circuit family.
- Accepts one-hot ballots one per cycle over a valid/ready handshake and keeps a saturating tally per candidate.
- After the ballot closes, runs a sequential max-search and presents a one-hot winner.
- Sits between a ballot source (keypad, UART decoder or test stimulus) and a display/result consumer.

---
 rtl/ballot_tally.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ballot_tally.sv
// ballot_tally: sequential plurality voter.
// Collects one-hot ballots over valid/ready, keeps a saturating tally per
// candidate, then scans the tallies one per cycle to pick a one-hot winner.
// Ties resolve to the highest candidate index.
// Optional: define BALLOT_TIE_EN to report whether the winner was tied.
module ballot_tally #(
    parameter int N_CAND   = 3,
    parameter int N_VOTERS = 5,
    parameter int CW       = $clog2(N_VOTERS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              vote_valid,
    input  logic [N_CAND-1:0] vote,
    output logic              vote_ready,
    input  logic              close,
    output logic              busy,
    output logic              result_valid,
    output logic [N_CAND-1:0] result,
    output logic              tie,
    output logic [CW-1:0]     rejected
);

    localparam int IW = (N_CAND > 1) ? $clog2(N_CAND) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SEARCH, S_DONE} state_t;

    state_t                       state_q;
    logic [N_CAND-1:0][CW-1:0]    tally_q;
    logic [CW-1:0]                rej_q;
    logic [CW-1:0]                cnt_q;
    logic [IW-1:0]                idx_q;
    logic [CW-1:0]                best_q;
    logic [IW-1:0]                best_idx_q;
    logic [N_CAND-1:0]            result_q;

    logic [CW-1:0]                cand_d;
    logic                         take_d;
    logic [IW-1:0]                win_idx_d;
    logic                         last_d;

    // Status outputs decode straight from the state register.
    assign vote_ready   = (state_q == S_COLLECT);
    assign busy         = (state_q == S_COLLECT) || (state_q == S_SEARCH);
    assign result_valid = (state_q == S_DONE);
    assign result       = result_q;
    assign rejected     = rej_q;

    // One search step: candidate idx_q displaces the best on >= (highest index wins ties).
    always_comb begin
        cand_d    = tally_q[idx_q];
        take_d    = (cand_d >= best_q);
        win_idx_d = take_d ? idx_q : best_idx_q;
        last_d    = (idx_q == IW'(N_CAND - 1));
    end

`ifdef BALLOT_TIE_EN
    logic tie_run_q;
    logic tie_q;
    assign tie = tie_q;

    // Tie tracking: a strictly greater candidate clears it, an equal one sets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tie_run_q <= 1'b0;
            tie_q     <= 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: tie_run_q <= 1'b0;
                S_SEARCH: begin
                    if (idx_q != '0) begin
                        if (cand_d > best_q)       tie_run_q <= 1'b0;
                        else if (cand_d == best_q) tie_run_q <= 1'b1;
                    end
                    if (last_d) begin
                        if (idx_q == '0)           tie_q <= 1'b0;
                        else if (cand_d > best_q)  tie_q <= 1'b0;
                        else if (cand_d == best_q) tie_q <= 1'b1;
                        else                       tie_q <= tie_run_q;
                    end
                end
                S_DONE: if (start) tie_q <= 1'b0;
                default: ;
            endcase
        end
    end
`else
    assign tie = 1'b0;
`endif

    // Main FSM: collect ballots, scan tallies, hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tally_q    <= '0;
            rej_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            result_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_COLLECT;
                        tally_q  <= '0;
                        rej_q    <= '0;
                        cnt_q    <= '0;
                        result_q <= '0;
                    end
                end
                S_COLLECT: begin
                    if (vote_valid) begin
                        if ($onehot(vote)) begin
                            for (int i = 0; i < N_CAND; i++)
                                if (vote[i] && (tally_q[i] != '1))
                                    tally_q[i] <= tally_q[i] + 1'b1;
                        end else if (rej_q != '1) begin
                            rej_q <= rej_q + 1'b1;
                        end
                        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    end
                    if (close || (vote_valid && (cnt_q == CW'(N_VOTERS - 1)))) begin
                        state_q    <= S_SEARCH;
                        idx_q      <= '0;
                        best_q     <= '0;
                        best_idx_q <= '0;
                    end
                end
                S_SEARCH: begin
                    if (take_d) begin
                        best_q     <= cand_d;
                        best_idx_q <= idx_q;
                    end
                    if (last_d) begin
                        state_q  <= S_DONE;
                        result_q <= N_CAND'(1) << win_idx_d;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
